// File: rtl/packet_pkg.sv
// rtl/packet_pkg.sv - packet layout, type codes and egress state encoding
package packet_pkg;

    localparam int PACKET_WIDTH = 16;
    localparam int SRC_LSB      = 0;
    localparam int SRC_W        = 4;
    localparam int TGT_LSB      = 4;
    localparam int TGT_W        = 4;
    localparam int TYPE_LSB     = 8;
    localparam int TYPE_W       = 2;
    localparam int PAY_LSB      = 10;
    localparam int PAY_W        = 6;

    typedef logic [PACKET_WIDTH-1:0] packet_t;

    typedef enum logic [1:0] {
        PKT_DATA = 2'd0,
        PKT_CTRL = 2'd1,
        PKT_MGMT = 2'd2,
        PKT_RSVD = 2'd3
    } pkt_type_e;

    typedef enum logic [1:0] {
        EGR_EMPTY   = 2'd0,
        EGR_PARTIAL = 2'd1,
        EGR_FULL    = 2'd2
    } egr_state_e;

    function automatic logic [TGT_W-1:0] pkt_target(input packet_t pkt);
        return pkt[TGT_LSB +: TGT_W];
    endfunction

endpackage

// File: rtl/egress_queue.sv
// rtl/egress_queue.sv - packet FIFO storage with wrapping pointers and occupancy count
module egress_queue
    import packet_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  packet_t       push_data,
    output packet_t       head,
    output logic [AW:0]   count
);

    packet_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/egress_port.sv
// rtl/egress_port.sv - switch egress: route check, output queue FSM, delivery counters
module egress_port
    import packet_pkg::*;
#(
    parameter int PORT_ID   = 0,
    parameter int EGR_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [PACKET_WIDTH-1:0] in_pkt,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [PACKET_WIDTH-1:0] out_pkt,
    input  logic                    out_ready,
    input  logic                    flush,
    output logic                    misroute_err,
    output logic [15:0]             tx_count,
    output logic [15:0]             misroute_count
);

    localparam int               CW          = $clog2(EGR_DEPTH) + 1;
    localparam logic [CW-1:0]    CNT_ALMOST  = CW'(EGR_DEPTH - 1);
    localparam logic [CW-1:0]    CNT_ONE     = CW'(1);

    egr_state_e       state;
    egr_state_e       state_next;
    logic             ready_en;
    logic             in_xfer;
    logic             out_xfer;
    logic             route_ok;
    logic             push;
    logic             pop;
    logic             misroute;
    logic [TGT_W-1:0] target;
    packet_t          head;
    logic [CW-1:0]    count;

    assign target    = pkt_target(in_pkt);
    assign route_ok  = target[PORT_ID];
    assign out_valid = (state != EGR_EMPTY);
    assign out_xfer  = out_valid && out_ready;
    // ready_en keeps in_ready low through reset and until the first edge after release
    assign in_ready  = ready_en && !flush && ((state != EGR_FULL) || out_xfer);
    assign in_xfer   = in_valid && in_ready;
    assign push      = in_xfer && route_ok;
    assign misroute  = in_xfer && !route_ok;
    assign pop       = out_xfer;
    assign out_pkt   = out_valid ? head : '0;

    egress_queue #(.DEPTH(EGR_DEPTH)) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .clear     (flush),
        .push_data (in_pkt),
        .head      (head),
        .count     (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EGR_EMPTY;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EGR_EMPTY;
        end else begin
            case (state)
                EGR_EMPTY:   if (push) state_next = EGR_PARTIAL;
                EGR_PARTIAL: begin
                    if (push && !pop && count == CNT_ALMOST)   state_next = EGR_FULL;
                    else if (pop && !push && count == CNT_ONE) state_next = EGR_EMPTY;
                end
                EGR_FULL:    if (pop && !push) state_next = EGR_PARTIAL;
                default:     state_next = EGR_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en       <= 1'b0;
            misroute_err   <= 1'b0;
            tx_count       <= '0;
            misroute_count <= '0;
        end else begin
            ready_en     <= 1'b1;
            misroute_err <= misroute;
            if (out_xfer && tx_count != 16'hFFFF)       tx_count       <= tx_count + 1'b1;
            if (misroute && misroute_count != 16'hFFFF) misroute_count <= misroute_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_egress_port.sv
// tb/tb_egress_port.sv - directed self-checking bench for egress_port (PORT_ID=2, depth 4)
module tb_egress_port;
    import packet_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_pkt = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_pkt;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic        misroute_err;
    logic [15:0] tx_count;
    logic [15:0] misroute_count;

    int errors = 0;
    int checks = 0;
    int exp_tx = 0;
    logic [15:0] mq[$];
    logic [15:0] p [5];
    logic [15:0] pkt;

    egress_port #(.PORT_ID(2), .EGR_DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_pkt         (in_pkt),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_pkt        (out_pkt),
        .out_ready      (out_ready),
        .flush          (flush),
        .misroute_err   (misroute_err),
        .tx_count       (tx_count),
        .misroute_count (misroute_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        p[0] = 16'h0445; p[1] = 16'h0842; p[2] = 16'h0C48; p[3] = 16'h1041; p[4] = 16'h1444;

        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pkt", out_pkt, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_misroute_err", misroute_err, 0);
        chk("rst_tx_count", tx_count, 0);
        chk("rst_misroute_count", misroute_count, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", in_ready, 0);
        tick();
        chk("ready_after_edge", in_ready, 1);

        // single correctly routed packet, latency 1
        in_valid = 1'b1; in_pkt = 16'h0241; out_ready = 1'b1;
        #1;
        chk("good_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("good_out_valid", out_valid, 1);
        chk("good_out_pkt", out_pkt, 16'h0241);
        tick();
        exp_tx = 1;
        chk("good_tx_count", tx_count, 1);
        chk("good_drained", out_valid, 0);

        // misrouted packet
        in_valid = 1'b1; in_pkt = 16'h0011;
        #1;
        chk("mis_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("mis_err_pulse", misroute_err, 1);
        chk("mis_no_out", out_valid, 0);
        chk("mis_count", misroute_count, 1);
        tick();
        chk("mis_err_clear", misroute_err, 0);
        chk("mis_count_hold", misroute_count, 1);

        // fill to full with output stalled, fifth is refused
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_pkt = p[i];
            #1;
            chk($sformatf("fill_ready_%0d", i), in_ready, (i < 4) ? 1 : 0);
            tick();
        end
        in_valid = 1'b0;
        chk("stall_head", out_pkt, p[0]);
        tick();
        chk("stall_head_stable", out_pkt, p[0]);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_valid_%0d", i), out_valid, 1);
            chk($sformatf("drain_pkt_%0d", i), out_pkt, p[i]);
            tick();
            exp_tx++;
        end
        chk("drain_empty", out_valid, 0);
        chk("drain_tx_count", tx_count, exp_tx);

        // full queue with simultaneous push and pop
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pkt = {6'(i + 1), 2'b00, 4'b0100, 4'b0001};
            in_valid = 1'b1; in_pkt = pkt;
            mq.push_back(pkt);
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            pkt = {6'(k + 20), 2'b10, 4'b1100, 4'b0010};
            in_pkt = pkt;
            #1;
            chk($sformatf("ff_ready_%0d", k), in_ready, 1);
            chk($sformatf("ff_pkt_%0d", k), out_pkt, mq[0]);
            tick();
            void'(mq.pop_front());
            mq.push_back(pkt);
            exp_tx++;
        end
        out_ready = 1'b0;
        #1;
        chk("ff_still_full", in_ready, 0);
        chk("ff_valid", out_valid, 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ff_drain_%0d", i), out_pkt, mq.pop_front());
            tick();
            exp_tx++;
        end
        chk("ff_empty", out_valid, 0);
        chk("ff_tx_count", tx_count, exp_tx);

        // flush with three queued
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_pkt = p[i];
            tick();
        end
        in_valid = 1'b0;
        chk("pre_flush_valid", out_valid, 1);
        flush = 1'b1; in_valid = 1'b1; in_pkt = p[3];
        #1;
        chk("flush_blocks_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_out_pkt", out_pkt, 0);
        chk("flush_tx_count", tx_count, exp_tx);
        chk("flush_mis_count", misroute_count, 1);
        tick();
        chk("flush_no_enqueue", out_valid, 0);

        // reset with two queued
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_pkt = p[i];
            tick();
        end
        in_valid = 1'b0;
        chk("pre_reset_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_pkt", out_pkt, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_tx_count", tx_count, 0);
        chk("mid_rst_mis_count", misroute_count, 0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_rst_no_stale_%0d", i), out_valid, 0);
        end
        chk("post_rst_tx_count", tx_count, 0);
        in_valid = 1'b1; in_pkt = 16'h0241;
        tick();
        in_valid = 1'b0;
        chk("post_rst_pkt", out_pkt, 16'h0241);
        tick();
        chk("post_rst_tx_one", tx_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/egress_port.md
EGRESS_PORT -- requirements
Module: egress_port

Interface
REQ-001 Parameter PORT_ID, default 0, meaning: switch port index 0..3 that this egress serves; selects which target bit is checked.
REQ-002 Parameter EGR_DEPTH, default 4, meaning: output queue depth in packets; power of two, minimum 2.
REQ-003 clk  input  1  meaning: single clock; all logic samples on its rising edge.
REQ-004 rst_n  input  1  meaning: asynchronous, active-low reset.
REQ-005 in_valid  input  1  meaning: crossbar presents a granted packet.
REQ-006 in_pkt  input  PACKET_WIDTH  meaning: packet with [3:0] source one-hot, [7:4] target mask, [9:8] type, [15:10] payload.
REQ-007 in_ready  output  1  meaning: egress accepts in_pkt this cycle.
REQ-008 out_valid  output  1  meaning: out_pkt holds a packet for the port interface.
REQ-009 out_pkt  output  PACKET_WIDTH  meaning: head-of-queue packet.
REQ-010 out_ready  input  1  meaning: port-side consumer accepts out_pkt.
REQ-011 flush  input  1  meaning: synchronous queue clear.
REQ-012 misroute_err  output  1  meaning: one-cycle pulse when an accepted packet lacks this port's target bit.
REQ-013 tx_count  output  16  meaning: packets delivered on the output, saturating.
REQ-014 misroute_count  output  16  meaning: packets discarded as misrouted, saturating.

Function
REQ-015 An input transfer occurs when in_valid and in_ready are both 1; an output transfer occurs when out_valid and out_ready are both 1.
REQ-016 in_ready SHALL be 1 when the queue is not full, or when it is full and an output transfer occurs in the same cycle; in_ready SHALL be 0 while flush is 1.
REQ-017 An input transfer whose in_pkt[4+PORT_ID] is 0 SHALL NOT be enqueued; misroute_err pulses on the following cycle and misroute_count increments.
REQ-018 A correctly routed input transfer into an empty queue SHALL appear on out_valid/out_pkt on the next cycle (latency 1).
REQ-019 Packets SHALL leave in arrival order; out_pkt SHALL remain stable while out_valid is 1 and out_ready is 0.
REQ-020 A simultaneous input and output transfer SHALL leave the occupancy unchanged, including when the queue is full.
REQ-021 Read and write pointers SHALL wrap modulo EGR_DEPTH; occupancy is tracked in a counter of width log2(EGR_DEPTH)+1.
REQ-022 FSM states: EMPTY (count 0), PARTIAL (0<count<EGR_DEPTH), FULL (count=EGR_DEPTH).
REQ-023 FSM transitions follow occupancy after each cycle's transfers: EMPTY->PARTIAL on push; PARTIAL->FULL on push to EGR_DEPTH; FULL->PARTIAL on pop; PARTIAL->EMPTY on pop to 0.
REQ-024 out_valid SHALL be 1 exactly when the state is not EMPTY.
REQ-025 flush SHALL force the EMPTY state on the next cycle, discard all queued packets, and block enqueue during that cycle; counters SHALL be unaffected.
REQ-026 tx_count increments on each output transfer; it and misroute_count SHALL hold at 16'hFFFF once reached.

Reset
REQ-027 On rst_n low, the block SHALL immediately set state EMPTY, pointers and occupancy to 0, out_valid 0, out_pkt 0, in_ready 0, misroute_err 0, and both counters to 0.
REQ-028 in_ready SHALL rise on the first clock edge after rst_n deasserts; asserting reset mid-transfer SHALL drop all queued packets without any output transfer.

Structure
REQ-029 PACKET_WIDTH, field position constants, the type enumeration, and the egress state enum SHALL reside in packet_pkg.
REQ-030 Queue storage SHALL be a single sub-module, egress_queue (memory, pointers, count); the FSM, route check, and counters SHALL remain in egress_port.

Verification
REQ-031 PORT_ID=2: push 16'h0241 with out_ready=1 -> out_valid=1 and out_pkt=16'h0241 one cycle later; tx_count=1.
REQ-032 PORT_ID=2: push 16'h0011 (target 4'b0001) -> no out_valid; misroute_err pulses once; misroute_count=1.
REQ-033 out_ready=0: push 5 valid packets -> 4 accepted, in_ready=0 on the 5th; raising out_ready drains all 4 in order.
REQ-034 Queue full with in_valid=1 and out_ready=1 held for 10 cycles -> one accepted and one delivered per cycle; state stays FULL.
REQ-035 Queue holding 3 packets, assert flush for 1 cycle -> out_valid=0 next cycle; tx_count unchanged.
REQ-036 Reset asserted with 2 packets queued -> all outputs 0 immediately; after release, no stale packet appears on out_valid.
